// File: rtl/control_unit_pkg.sv
// Shared RV32I control encodings: opcodes, ALU classes, operand/write-back selects
// and the control word that travels down the pipeline from ID.
package control_unit_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RFUNC = 2'b10,
        ALU_IFUNC = 2'b11
    } alu_class_t;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_ZERO = 2'b10,
        A_RSVD = 2'b11
    } mux_a_t;

    typedef enum logic [1:0] {
        B_RS2   = 2'b00,
        B_IMM   = 2'b01,
        B_RSVD2 = 2'b10,
        B_RSVD3 = 2'b11
    } mux_b_t;

    typedef enum logic [1:0] {
        D_ALU  = 2'b00,
        D_MEM  = 2'b01,
        D_PC4  = 2'b10,
        D_RSVD = 2'b11
    } mux_data_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       branch;
        alu_class_t alu;
        mux_a_t     mux_a;
        mux_b_t     mux_b;
        mux_data_t  mux_data;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, A_RS1, B_RS2, D_ALU};

endpackage

// File: rtl/control_decoder.sv
// Purely combinational opcode-to-control-word decoder; unknown opcodes become a bubble.
module control_decoder
    import control_unit_pkg::*;
(
    input  logic [6:0]  opcode,
    output ctrl_word_t  ctrl
);

    // Opcode lookup; every field starts from the NOP word so only set bits are listed.
    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu       = ALU_RFUNC;
            end
            OP_IMM: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu       = ALU_IFUNC;
                ctrl.mux_b     = B_IMM;
            end
            OP_LOAD: begin
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.mux_b     = B_IMM;
                ctrl.mux_data  = D_MEM;
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.mux_b     = B_IMM;
            end
            OP_BRANCH: begin
                ctrl.branch    = 1'b1;
                ctrl.alu       = ALU_SUB;
            end
            OP_JAL: begin
                ctrl.reg_write = 1'b1;
                ctrl.mux_a     = A_PC;
                ctrl.mux_b     = B_IMM;
                ctrl.mux_data  = D_PC4;
            end
            OP_JALR: begin
                ctrl.reg_write = 1'b1;
                ctrl.mux_b     = B_IMM;
                ctrl.mux_data  = D_PC4;
            end
            OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.mux_a     = A_ZERO;
                ctrl.mux_b     = B_IMM;
            end
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.mux_a     = A_PC;
                ctrl.mux_b     = B_IMM;
            end
            default: begin
                ctrl = CTRL_NOP;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ID-stage main decoder: registers the decoded control word so it appears one
// clock after its opcode; synchronous reset clears it to the bubble word.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] instr_opcode,
    output logic       mem_read_en,
    output logic       mem_write_en,
    output logic       reg_write_en,
    output logic       branch_flag,
    output logic [1:0] alu_ctrl,
    output logic [1:0] mux_a_sel,
    output logic [1:0] mux_b_sel,
    output logic [1:0] mux_data_sel
);

    ctrl_word_t ctrl_s;
    ctrl_word_t ctrl_r;

    control_decoder u_decoder (
        .opcode (instr_opcode),
        .ctrl   (ctrl_s)
    );

    // Control word pipeline register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_r <= CTRL_NOP;
        end else begin
            ctrl_r <= ctrl_s;
        end
    end

    assign mem_read_en  = ctrl_r.mem_read;
    assign mem_write_en = ctrl_r.mem_write;
    assign reg_write_en = ctrl_r.reg_write;
    assign branch_flag  = ctrl_r.branch;
    assign alu_ctrl     = ctrl_r.alu;
    assign mux_a_sel    = ctrl_r.mux_a;
    assign mux_b_sel    = ctrl_r.mux_b;
    assign mux_data_sel = ctrl_r.mux_data;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, hand-written
// stability sequence, then random opcodes against a lookup-table reference model.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] instr_opcode;
    logic       mem_read_en;
    logic       mem_write_en;
    logic       reg_write_en;
    logic       branch_flag;
    logic [1:0] alu_ctrl;
    logic [1:0] mux_a_sel;
    logic [1:0] mux_b_sel;
    logic [1:0] mux_data_sel;

    int checks = 0;
    int errors = 0;

    control_unit dut (
        .clk          (clk),
        .rst          (rst),
        .instr_opcode (instr_opcode),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .reg_write_en (reg_write_en),
        .branch_flag  (branch_flag),
        .alu_ctrl     (alu_ctrl),
        .mux_a_sel    (mux_a_sel),
        .mux_b_sel    (mux_b_sel),
        .mux_data_sel (mux_data_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word layout: {rd, wr, rw, br, alu[1:0], a[1:0], b[1:0], d[1:0]}
    typedef struct {
        string       name;
        logic        rst;
        logic [6:0]  op;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[14];

    // Reference: the opcode table written out as a lookup, zero for anything unlisted.
    function automatic logic [11:0] ref_word(input logic [6:0] op);
        logic [11:0] w;
        w = 12'b0;
        if (op == 7'b0110011) w = 12'b0_0_1_0_10_00_00_00;
        if (op == 7'b0010011) w = 12'b0_0_1_0_11_00_01_00;
        if (op == 7'b0000011) w = 12'b1_0_1_0_00_00_01_01;
        if (op == 7'b0100011) w = 12'b0_1_0_0_00_00_01_00;
        if (op == 7'b1100011) w = 12'b0_0_0_1_01_00_00_00;
        if (op == 7'b1101111) w = 12'b0_0_1_0_00_01_01_10;
        if (op == 7'b1100111) w = 12'b0_0_1_0_00_00_01_10;
        if (op == 7'b0110111) w = 12'b0_0_1_0_00_10_01_00;
        if (op == 7'b0010111) w = 12'b0_0_1_0_00_01_01_00;
        return w;
    endfunction

    function automatic logic [11:0] dut_word();
        return {mem_read_en, mem_write_en, reg_write_en, branch_flag,
                alu_ctrl, mux_a_sel, mux_b_sel, mux_data_sel};
    endfunction

    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = dut_word();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    // Present inputs on the falling edge, compare just after the next rising edge.
    task automatic step(input logic r, input logic [6:0] op);
        @(negedge clk);
        rst = r;
        instr_opcode = op;
        @(posedge clk);
        #1;
    endtask

    logic [6:0] valid_ops[9];

    initial begin
        logic [11:0] held;
        logic [6:0]  op;
        logic        r;

        rst = 1'b1;
        instr_opcode = 7'b0;

        vecs[0]  = '{"reset_rtype", 1'b1, 7'b0110011, 12'b0};
        vecs[1]  = '{"rtype",       1'b0, 7'b0110011, 12'b0_0_1_0_10_00_00_00};
        vecs[2]  = '{"load",        1'b0, 7'b0000011, 12'b1_0_1_0_00_00_01_01};
        vecs[3]  = '{"unknown_7f",  1'b0, 7'b1111111, 12'b0};
        vecs[4]  = '{"store",       1'b0, 7'b0100011, 12'b0_1_0_0_00_00_01_00};
        vecs[5]  = '{"branch",      1'b0, 7'b1100011, 12'b0_0_0_1_01_00_00_00};
        vecs[6]  = '{"jal",         1'b0, 7'b1101111, 12'b0_0_1_0_00_01_01_10};
        vecs[7]  = '{"lui",         1'b0, 7'b0110111, 12'b0_0_1_0_00_10_01_00};
        vecs[8]  = '{"jalr",        1'b0, 7'b1100111, 12'b0_0_1_0_00_00_01_10};
        vecs[9]  = '{"auipc",       1'b0, 7'b0010111, 12'b0_0_1_0_00_01_01_00};
        vecs[10] = '{"ialu",        1'b0, 7'b0010011, 12'b0_0_1_0_11_00_01_00};
        vecs[11] = '{"unknown_00",  1'b0, 7'b0000000, 12'b0};
        vecs[12] = '{"store_rst",   1'b1, 7'b0100011, 12'b0};
        vecs[13] = '{"store_after", 1'b0, 7'b0100011, 12'b0_1_0_0_00_00_01_00};

        valid_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                      7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rst, vecs[i].op);
            check(vecs[i].name, vecs[i].exp);
        end

        // Opcode change between edges must not disturb the registered word.
        step(1'b0, 7'b0000011);
        check("load_again", 12'b1_0_1_0_00_00_01_01);
        held = 12'b1_0_1_0_00_00_01_01;
        @(negedge clk);
        instr_opcode = 7'b0100011;
        #2;
        check("stable_between_edges", held);
        @(posedge clk);
        #1;
        check("store_next_edge", 12'b0_1_0_0_00_00_01_00);

        // Repeated unknown opcode held across several edges stays a bubble.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 7'b1111111);
            check("unknown_held", 12'b0);
        end

        // Random phase against the lookup model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(1, 0) == 0) begin
                op = valid_ops[$urandom_range(8, 0)];
            end else begin
                op = 7'($urandom);
            end
            r = ($urandom_range(19, 0) == 0);
            step(r, op);
            check(r ? "rand_reset" : "rand_decode", r ? 12'b0 : ref_word(op));
            checks++;
            if (mem_read_en === 1'b1 && mem_write_en === 1'b1) begin
                errors++;
                $display("FAIL rd_wr_exclusive got rd=%b wr=%b expected not both 1",
                         mem_read_en, mem_write_en);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Main decoder for the RV32I five-stage pipeline, located in the ID stage. It takes the 7-bit opcode of the instruction being decoded and produces the datapath controls that travel down the pipeline: memory enables, register write-back enable, the branch flag, the ALU operation class and the three mux selects. All outputs are registered, so the control word appears one clock after its opcode is presented.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- instr_opcode  in  7  instruction bits [6:0] of the instruction in ID
- mem_read_en  out  1  data memory read enable (loads)
- mem_write_en  out  1  data memory write enable (stores)
- reg_write_en  out  1  register file write-back enable
- branch_flag  out  1  conditional branch instruction
- alu_ctrl  out  2  ALU operation class:
  - 00 = add
  - 01 = subtract/compare
  - 10 = R-type funct decode
  - 11 = I-type funct decode
- mux_a_sel  out  2  ALU operand A select:
  - 00 = rs1
  - 01 = PC
  - 10 = zero
  - 11 = reserved
- mux_b_sel  out  2  ALU operand B select:
  - 00 = rs2
  - 01 = immediate
  - 10, 11 = reserved
- mux_data_sel  out  2  write-back data select:
  - 00 = ALU result
  - 01 = memory data
  - 10 = PC+4
  - 11 = reserved

## Operation
Control word per opcode, given in the order rd, wr, rw, br, alu, a, b, d (fields not listed are 0):
- R-type 0110011: 0,0,1,0, 10, 00, 00, 00
- I-ALU 0010011: 0,0,1,0, 11, 00, 01, 00
- LOAD 0000011: 1,0,1,0, 00, 00, 01, 01
- STORE 0100011: 0,1,0,0, 00, 00, 01, 00
- BRANCH 1100011: 0,0,0,1, 01, 00, 00, 00
- JAL 1101111: 0,0,1,0, 00, 01, 01, 10
- JALR 1100111: 0,0,1,0, 00, 00, 01, 10
- LUI 0110111: 0,0,1,0, 00, 10, 01, 00
- AUIPC 0010111: 0,0,1,0, 00, 01, 01, 00

Any other opcode, including 0000000 and 1111111:
- Produces the all-zero control word, which acts as a NOP/bubble.
- No memory access, no write-back, no branch.
- No error output.

Invariant: mem_read_en and mem_write_en are never both 1.

## Timing
- Outputs are registers.
- On each rising edge of clk with rst=0, the outputs load the control word decoded from the instr_opcode value present at that edge.
- Latency is exactly 1 cycle; there is no handshake or stall input, so a new opcode is accepted every cycle.
- Reset:
  - On a rising edge with rst=1, every output is forced to 0 (all 1-bit outputs 0, all 2-bit outputs 00), regardless of instr_opcode.
  - Asserting rst mid-stream discards the pending decode.
  - On the first edge after rst deasserts, the current opcode is decoded.
- Between edges, outputs are stable; opcode changes have no effect until the next edge.

## Structure
- Shared package, for use by the ID, EX, MEM and WB stages:
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC)
  - ALU class encodings
  - mux select encodings for A, B and data
- Sub-module: a purely combinational control_decoder (opcode in, control word out).
- control_unit wraps control_decoder with the reset-able output register.

## Test plan
- Reset: rst=1 for 1 edge with opcode 0110011 -> all outputs 0.
- R-type then LOAD on consecutive cycles, 0110011 then 0000011:
  - After edge 1: rw=1, alu=10, a=00, b=00, d=00.
  - After edge 2: rd=1, rw=1, alu=00, b=01, d=01.
- STORE 0100011 -> wr=1, rw=0, rd=0, alu=00, b=01, d=00. BRANCH 1100011 -> br=1, alu=01, rw=0, b=00.
- JAL 1101111 -> rw=1, a=01, b=01, d=10. LUI 0110111 -> a=10, b=01, rw=1.
- Unknown opcode 1111111, held after a LOAD -> all outputs 0 one cycle later.
- Mid-stream reset: rst=1 at the same edge as STORE -> outputs 0 (wr=0). With rst=0 on the next edge -> wr=1.
